// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  localparam int          XLEN           = 32;
  localparam int          CNT_W          = 6;
  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the EX-stage decoder and the HI/LO unit.
interface hilo_muldiv_if;
  import muldiv_pkg::*;

  logic        start;
  op_e         op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo, mt_data, flush,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo, mt_data, flush,
    output busy, hi, lo
  );

endinterface

// File: rtl/hilo_muldiv_div_restoring_step.sv
// One radix-2 restoring division step over the {remainder, quotient} pair.
module div_restoring_step
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // Shift in the next dividend bit, keep the trial difference if non-negative.
  always_comb begin
    shifted_s = {rem_in, quo_in[XLEN-1]};
    diff_s    = shifted_s - {1'b0, divisor};
    if (diff_s[XLEN] == 1'b0) begin
      rem_out = diff_s[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic         clk,
  input  logic         reset,
  hilo_muldiv_if.slave bus
);

  state_e            state_r;
  state_e            next_state_s;
  logic              busy_r;
  logic [31:0]       hi_r;
  logic [31:0]       lo_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [63:0]       prod_pipe_r [MUL_CYCLES];
  logic [31:0]       rem_r;
  logic [31:0]       quo_r;
  logic [31:0]       divisor_r;
  logic [31:0]       dividend_r;
  logic              neg_q_r;
  logic              neg_rem_r;
  logic              div_zero_r;

  logic              signed_op_s;
  logic              accept_s;
  logic              last_mul_s;
  logic              last_div_s;
  logic signed [32:0] a_ext_s;
  logic signed [32:0] b_ext_s;
  logic signed [63:0] prod_s;
  logic [31:0]       step_rem_s;
  logic [31:0]       step_quo_s;
  logic [31:0]       fix_q_s;
  logic [31:0]       fix_rem_s;

  assign signed_op_s = ~bus.op[0];
  assign accept_s    = (state_r == S_IDLE) && bus.start && !bus.flush;
  assign last_mul_s  = (state_r == S_MUL) && (cnt_r == CNT_W'(MUL_CYCLES - 1));
  assign last_div_s  = (state_r == S_DIV) && (cnt_r == CNT_W'(DIV_CYCLES - 1));

  // Operands are sign- or zero-extended so one signed multiplier serves both forms.
  always_comb begin
    a_ext_s   = {signed_op_s & bus.rs_data[31], bus.rs_data};
    b_ext_s   = {signed_op_s & bus.rt_data[31], bus.rt_data};
    prod_s    = 64'(a_ext_s) * 64'(b_ext_s);
    fix_q_s   = neg_if(quo_r, neg_q_r);
    fix_rem_s = neg_if(rem_r, neg_rem_r);
  end

  div_restoring_step u_div_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (divisor_r),
    .rem_out (step_rem_s),
    .quo_out (step_quo_s)
  );

  // Next-state logic; flush returns to IDLE from anywhere, ahead of completion.
  always_comb begin
    next_state_s = state_r;
    if (bus.flush) begin
      next_state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) next_state_s = bus.op[1] ? S_DIV : S_MUL;
          else           next_state_s = S_IDLE;
        end
        S_MUL: begin
          if (last_mul_s) next_state_s = S_IDLE;
          else            next_state_s = S_MUL;
        end
        S_DIV: begin
          if (last_div_s) next_state_s = S_FIX;
          else            next_state_s = S_DIV;
        end
        S_FIX:   next_state_s = S_IDLE;
        default: next_state_s = S_IDLE;
      endcase
    end
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != S_IDLE);
    end
  end

  // Iteration counter and divider working registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= '0;
      rem_r      <= 32'd0;
      quo_r      <= 32'd0;
      divisor_r  <= 32'd0;
      dividend_r <= 32'd0;
      neg_q_r    <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r      <= '0;
      rem_r      <= 32'd0;
      quo_r      <= neg_if(bus.rs_data, signed_op_s & bus.rs_data[31]);
      divisor_r  <= neg_if(bus.rt_data, signed_op_s & bus.rt_data[31]);
      dividend_r <= bus.rs_data;
      neg_q_r    <= signed_op_s & (bus.rs_data[31] ^ bus.rt_data[31]);
      neg_rem_r  <= signed_op_s & bus.rs_data[31];
      div_zero_r <= (bus.rt_data == 32'd0);
    end else if (state_r == S_DIV) begin
      cnt_r <= cnt_r + CNT_W'(1);
      rem_r <= step_rem_s;
      quo_r <= step_quo_s;
    end else if (state_r == S_MUL) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Product captured at issue and carried down a MUL_CYCLES-deep chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_CYCLES; i++) prod_pipe_r[i] <= 64'd0;
    end else begin
      if (accept_s) prod_pipe_r[0] <= prod_s;
      for (int i = 1; i < MUL_CYCLES; i++) prod_pipe_r[i] <= prod_pipe_r[i-1];
    end
  end

  // HI/LO architectural state: MTHI/MTLO in IDLE, results on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (!bus.flush) begin
      case (state_r)
        S_IDLE: begin
          if (!bus.start) begin
            if (bus.mthi) hi_r <= bus.mt_data;
            if (bus.mtlo) lo_r <= bus.mt_data;
          end
        end
        S_MUL: begin
          if (last_mul_s) {hi_r, lo_r} <= prod_pipe_r[MUL_CYCLES-1];
        end
        S_FIX: begin
          if (div_zero_r) begin
            lo_r <= DIV_BY_ZERO_LO;
            hi_r <= dividend_r;
          end else begin
            lo_r <= fix_q_s;
            hi_r <= fix_rem_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed-vector bench for hilo_muldiv with hand-computed HI/LO results.
module tb_hilo_muldiv;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  hilo_muldiv_if bus();

  hilo_muldiv #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    tick(1);
    bus.start   = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
  endtask

  task automatic run(input string tag, input op_e op, input logic [31:0] a, input logic [31:0] b,
                     input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(op, a, b);
    count_busy(n);
    check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = OP_MULT;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    bus.mt_data = 32'd0;
    bus.flush   = 1'b0;
    tick(2);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    reset = 1'b0;
    tick(1);

    run("mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'd3,         2,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  32'hFFFF_FFFE, 32'h0000_0001);
    run("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu",       OP_DIVU,  32'd100,       32'd7,         33, 32'd2,         32'd14);
    run("divu_zero",  OP_DIVU,  32'h0000_1234, 32'd0,         33, 32'h0000_1234, 32'hFFFF_FFFF);
    run("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         32'h8000_0000);

    // Preload both registers with separate writes.
    bus.mthi = 1'b1; bus.mt_data = 32'h0000_AAAA; tick(1);
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.mt_data = 32'h0000_5555; tick(1);
    bus.mtlo = 1'b0;
    check("preload_hi", bus.hi, 32'h0000_AAAA);
    check("preload_lo", bus.lo, 32'h0000_5555);

    // Flush in busy cycle 10.
    issue(OP_DIVU, 32'd100, 32'd7);
    tick(9);
    check("flush10_busy_before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1; tick(1); bus.flush = 1'b0;
    check("flush10_busy", 32'(bus.busy), 32'd0);
    tick(2);
    check("flush10_hi", bus.hi, 32'h0000_AAAA);
    check("flush10_lo", bus.lo, 32'h0000_5555);

    // Flush in busy cycle 33 (the FIX cycle) suppresses the write.
    issue(OP_DIVU, 32'd100, 32'd7);
    tick(32);
    check("flush33_busy_before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1; tick(1); bus.flush = 1'b0;
    check("flush33_busy", 32'(bus.busy), 32'd0);
    tick(1);
    check("flush33_hi", bus.hi, 32'h0000_AAAA);
    check("flush33_lo", bus.lo, 32'h0000_5555);

    // start together with flush in IDLE is dropped.
    bus.flush = 1'b1;
    issue(OP_MULT, 32'd5, 32'd5);
    bus.flush = 1'b0;
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    tick(3);
    check("flush_start_lo", bus.lo, 32'h0000_5555);

    // Asynchronous reset between edges mid-divide.
    issue(OP_DIVU, 32'd100, 32'd7);
    tick(4);
    #3 reset = 1'b1;
    #1;
    check("areset_busy", 32'(bus.busy), 32'd0);
    check("areset_hi", bus.hi, 32'd0);
    check("areset_lo", bus.lo, 32'd0);
    #1 reset = 1'b0;
    tick(2);
    check("areset_idle", 32'(bus.busy), 32'd0);

    // start wins over a simultaneous mthi.
    bus.mthi = 1'b1; bus.mt_data = 32'h0000_DEAD;
    issue(OP_MULTU, 32'd5, 32'd7);
    bus.mthi = 1'b0;
    count_busy(n);
    check("start_mthi_cycles", 32'(n), 32'd2);
    check("start_mthi_hi", bus.hi, 32'd0);
    check("start_mthi_lo", bus.lo, 32'd35);

    // mtlo while busy is ignored; a flush then leaves lo at its old value.
    issue(OP_DIV, 32'd50, 32'd3);
    bus.mtlo = 1'b1; bus.mt_data = 32'h0000_BEEF; tick(1);
    bus.mtlo = 1'b0;
    bus.flush = 1'b1; tick(1); bus.flush = 1'b0;
    tick(1);
    check("mtlo_busy_lo", bus.lo, 32'd35);
    check("mtlo_busy_hi", bus.hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
